bpsk_demodulator: RTL

- Coherent BPSK receiver. It is the receive-side counterpart of the BPSK mixer/modulator.
- Each enabled clock it multiplies one signed 16-bit BPSK sample by the matching signed reference sine sample. It integrates the products over one symbol (integrate-and-dump) and decides the bit from the sign of the correlation.
- It sits after the ADC/sample path and before the BPSK controller's bit sink. Decided bits are delivered with a one-cycle valid strobe.

---
 rtl/bpsk_pkg.sv | 21 ++
 rtl/bpsk_demodulator_mac.sv | 69 ++++++
 rtl/bpsk_demodulator.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/bpsk_pkg.sv
// Shared definitions for the BPSK receive path.
//   demod_state_t : demodulator FSM states
//   BPSK_ONE/ZERO : bit mapping (1 -> +sine, 0 -> -sine), common with the mixer
//   acc_w_min()   : smallest correlation width that cannot overflow
package bpsk_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INTEGRATE = 2'd1,
        DRAIN     = 2'd2
    } demod_state_t;

    localparam logic BPSK_ONE  = 1'b1;
    localparam logic BPSK_ZERO = 1'b0;

    // Full-precision product plus growth from summing samples_per_bit terms.
    function automatic int acc_w_min(input int sample_w, input int samples_per_bit);
        return 2 * sample_w + $clog2(samples_per_bit);
    endfunction

endpackage

// File: rtl/bpsk_demodulator_mac.sv
// Registered multiply followed by an accumulate-with-dump stage.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   sample_v     : bpsk/sine pair is valid this cycle
//   sample_last  : this pair is the last sample of a symbol
//   bpsk, sine   : signed samples
//   clear        : zero the accumulator on this edge (partial symbol discarded)
//   prod_v       : product register holds a valid product
//   dump         : the product being consumed closes a symbol
//   acc          : running accumulator
//   dump_val     : acc + current product, i.e. the symbol correlation at a dump
module bpsk_demodulator_mac #(
    parameter int SAMPLE_W = 16,
    parameter int ACC_W    = 40
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_v,
    input  logic                sample_last,
    input  logic [SAMPLE_W-1:0] bpsk,
    input  logic [SAMPLE_W-1:0] sine,
    input  logic                clear,
    output logic                prod_v,
    output logic                dump,
    output logic [ACC_W-1:0]    acc,
    output logic [ACC_W-1:0]    dump_val
);

    localparam int PROD_W = 2 * SAMPLE_W;

    logic signed [PROD_W-1:0] bpsk_ext;
    logic signed [PROD_W-1:0] sine_ext;
    logic signed [PROD_W-1:0] prod;
    logic                     prod_last;
    logic [ACC_W-1:0]         prod_ext;

    // Operands widened to the product width first so the multiply is exact.
    assign bpsk_ext = {{SAMPLE_W{bpsk[SAMPLE_W-1]}}, bpsk};
    assign sine_ext = {{SAMPLE_W{sine[SAMPLE_W-1]}}, sine};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod      <= '0;
            prod_v    <= 1'b0;
            prod_last <= 1'b0;
        end else begin
            prod      <= bpsk_ext * sine_ext;
            prod_v    <= sample_v;
            prod_last <= sample_v & sample_last;
        end
    end

    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign dump     = prod_v & prod_last;
    assign dump_val = acc + prod_ext;

    // A dump hands the finished sum to the top and restarts from zero, so the
    // next symbol's first product lands in a clean accumulator on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (dump || clear) begin
            acc <= '0;
        end else if (prod_v) begin
            acc <= dump_val;
        end
    end

endmodule

// File: rtl/bpsk_demodulator.sv
// Coherent BPSK integrate-and-dump receiver.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   demod_ena   : a sample is presented on every cycle this is high
//   bit_sync    : presented sample is sample 0 of a new symbol
//   bpsk, sine  : received sample and coherent reference, signed
//   ena_demod   : FSM is integrating
//   data_out    : last decided bit (held)
//   data_valid  : one-cycle strobe for a new decision
//   corr        : correlation of the last decided symbol (held)
//   bit_count   : decisions since reset, wrapping
//
// state     | meaning
// IDLE      | waiting for demod_ena; accumulator held at zero
// INTEGRATE | capturing samples, symbols back-to-back
// DRAIN     | one cycle after enable drops; partial symbol discarded
module bpsk_demodulator
    import bpsk_pkg::*;
#(
    parameter int SAMPLE_W        = 16,
    parameter int SAMPLES_PER_BIT = 64,
    parameter int ACC_W           = 40
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                demod_ena,
    input  logic                bit_sync,
    input  logic [SAMPLE_W-1:0] bpsk,
    input  logic [SAMPLE_W-1:0] sine,
    output logic                ena_demod,
    output logic                data_out,
    output logic                data_valid,
    output logic [ACC_W-1:0]    corr,
    output logic [15:0]         bit_count
);

    if (SAMPLES_PER_BIT < 2) begin : g_spb_check
        $error("bpsk_demodulator: SAMPLES_PER_BIT must be at least 2");
    end
    if (ACC_W < acc_w_min(SAMPLE_W, SAMPLES_PER_BIT)) begin : g_acc_w_check
        $error("bpsk_demodulator: ACC_W too narrow for SAMPLE_W/SAMPLES_PER_BIT");
    end

    localparam int               CNT_W    = $clog2(SAMPLES_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_BIT - 1);

    demod_state_t     state;
    demod_state_t     state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] idx;
    logic             sample_v;
    logic             sample_last;
    logic             clear;

    logic             prod_v;
    logic             dump;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] dump_val;
    logic [15:0]      bit_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // cnt is the index of the sample presented in the current cycle.
    // A bit_sync forces index 0, so a sync on what would have been the last
    // sample suppresses that symbol's dump.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        idx         = cnt;
        sample_v    = 1'b0;
        sample_last = 1'b0;
        clear       = 1'b0;
        case (state)
            IDLE: begin
                clear = 1'b1;
                if (demod_ena) begin
                    state_next = INTEGRATE;
                    sample_v   = 1'b1;
                    cnt_next   = CNT_W'(1);
                end
            end
            INTEGRATE: begin
                if (!demod_ena) begin
                    state_next = DRAIN;
                    cnt_next   = '0;
                end else begin
                    sample_v = 1'b1;
                    if (bit_sync) begin
                        clear = 1'b1;
                        idx   = '0;
                    end
                    sample_last = (idx == CNT_LAST);
                    cnt_next    = sample_last ? '0 : idx + CNT_W'(1);
                end
            end
            DRAIN: begin
                clear      = 1'b1;
                cnt_next   = '0;
                state_next = IDLE;
            end
            default: begin
                clear      = 1'b1;
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    bpsk_demodulator_mac #(
        .SAMPLE_W (SAMPLE_W),
        .ACC_W    (ACC_W)
    ) u_mac (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_v    (sample_v),
        .sample_last (sample_last),
        .bpsk        (bpsk),
        .sine        (sine),
        .clear       (clear),
        .prod_v      (prod_v),
        .dump        (dump),
        .acc         (acc),
        .dump_val    (dump_val)
    );

    // A dump reported here may coincide with demod_ena falling; the finished
    // symbol is still delivered because the dump only depends on the product
    // pipeline, not on the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_valid <= 1'b0;
            data_out   <= 1'b0;
            corr       <= '0;
            bit_cnt_q  <= '0;
        end else begin
            data_valid <= dump;
            if (dump) begin
                corr      <= dump_val;
                data_out  <= dump_val[ACC_W-1] ? BPSK_ZERO : BPSK_ONE;
                bit_cnt_q <= bit_cnt_q + 16'd1;
            end
        end
    end

    assign ena_demod = (state == INTEGRATE);
    assign bit_count = bit_cnt_q;

endmodule
